// File: rtl/fpu_fclass_arbiter.sv
// Two-port round-robin arbiter in front of a shared FP classifier; the granted operand's
// one-hot fclass mask is held in an output register. Optional counters: FPU_FCLASS_STATS_EN.
module fpu_fclass_arbiter #(
   parameter int STD   = 15,
   parameter int MAN   = 7,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [STD:0]     req0_data,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [STD:0]     req1_data,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [9:0]       out_mask,
   output logic             out_id,
   output logic [TAG_W-1:0] out_tag
`ifdef FPU_FCLASS_STATS_EN
   ,
   input  logic             stat_clr,
   output logic [15:0]      stat_grant0,
   output logic [15:0]      stat_grant1,
   output logic [15:0]      stat_nan
`endif
);

   localparam int EW = STD - MAN;

   function automatic logic [9:0] classify(input logic [STD:0] x);
      logic           sgn;
      logic [EW-1:0]  e;
      logic [MAN-1:0] m;
      logic [9:0]     r;
      sgn = x[STD];
      e   = x[STD-1:MAN];
      m   = x[MAN-1:0];
      r   = '0;
      if (&e) begin
         if (m == '0)       r[sgn ? 0 : 7] = 1'b1;
         else if (m[MAN-1]) r[9] = 1'b1;
         else               r[8] = 1'b1;
      end else if (e == '0) begin
         if (m == '0) r[sgn ? 3 : 4] = 1'b1;
         else         r[sgn ? 2 : 5] = 1'b1;
      end else begin
         r[sgn ? 1 : 6] = 1'b1;
      end
      return r;
   endfunction

   logic             out_valid_q, out_valid_d;
   logic [9:0]       out_mask_q, out_mask_d;
   logic             out_id_q, out_id_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic             rr_ptr_q, rr_ptr_d;

   logic       slot_free;
   logic       can_grant;
   logic       grant0;
   logic       grant1;
   logic       grant_any;
   logic [9:0] grant_mask;

   // Grants are suppressed during reset so the requesters never see a handshake that is then lost.
   assign slot_free  = !out_valid_q || out_ready;
   assign can_grant  = slot_free && !flush && !rst;
   assign grant0     = can_grant && req0_valid && (!req1_valid || !rr_ptr_q);
   assign grant1     = can_grant && req1_valid && (!req0_valid || rr_ptr_q);
   assign grant_any  = grant0 || grant1;
   assign grant_mask = classify(grant1 ? req1_data : req0_data);

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      out_valid_d = out_valid_q;
      out_mask_d  = out_mask_q;
      out_id_d    = out_id_q;
      out_tag_d   = out_tag_q;
      rr_ptr_d    = rr_ptr_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (grant_any) begin
         out_valid_d = 1'b1;
         out_mask_d  = grant_mask;
         out_id_d    = grant1;
         out_tag_d   = grant1 ? req1_tag : req0_tag;
         rr_ptr_d    = !grant1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_mask_q  <= '0;
         out_id_q    <= 1'b0;
         out_tag_q   <= '0;
         rr_ptr_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_mask_q  <= out_mask_d;
         out_id_q    <= out_id_d;
         out_tag_q   <= out_tag_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_mask  = out_mask_q;
   assign out_id    = out_id_q;
   assign out_tag   = out_tag_q;

`ifdef FPU_FCLASS_STATS_EN
   logic [15:0] stat_grant0_q, stat_grant0_d;
   logic [15:0] stat_grant1_q, stat_grant1_d;
   logic [15:0] stat_nan_q, stat_nan_d;

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   always_comb begin
      stat_grant0_d = stat_grant0_q;
      stat_grant1_d = stat_grant1_q;
      stat_nan_d    = stat_nan_q;
      if (stat_clr) begin
         stat_grant0_d = '0;
         stat_grant1_d = '0;
         stat_nan_d    = '0;
      end else begin
         if (grant0) stat_grant0_d = sat_inc(stat_grant0_q);
         if (grant1) stat_grant1_d = sat_inc(stat_grant1_q);
         if (grant_any && (grant_mask[9] || grant_mask[8])) stat_nan_d = sat_inc(stat_nan_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_grant0_q <= '0;
         stat_grant1_q <= '0;
         stat_nan_q    <= '0;
      end else begin
         stat_grant0_q <= stat_grant0_d;
         stat_grant1_q <= stat_grant1_d;
         stat_nan_q    <= stat_nan_d;
      end
   end

   assign stat_grant0 = stat_grant0_q;
   assign stat_grant1 = stat_grant1_q;
   assign stat_nan    = stat_nan_q;
`endif

endmodule

// File: tb/tb_fpu_fclass_arbiter.sv
// Bench for fpu_fclass_arbiter: directed scenarios plus randomized traffic scored against
// a rule-level model of the arbiter and fclass categories (FPU_FCLASS_STATS_EN aware).
module tb_fpu_fclass_arbiter;

   localparam int STD   = 15;
   localparam int MAN   = 7;
   localparam int TAG_W = 4;
   localparam int EW    = STD - MAN;

   logic             clk = 1'b0;
   logic             rst, flush;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [STD:0]     req0_data, req1_data;
   logic [TAG_W-1:0] req0_tag, req1_tag;
   logic             out_valid, out_ready, out_id;
   logic [9:0]       out_mask;
   logic [TAG_W-1:0] out_tag;
`ifdef FPU_FCLASS_STATS_EN
   logic             stat_clr;
   logic [15:0]      stat_grant0, stat_grant1, stat_nan;
   int               m_g0, m_g1, m_nan;
`endif

   // clock / reset
   always #5 clk = ~clk;

   fpu_fclass_arbiter #(.STD(STD), .MAN(MAN), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_tag(req1_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_id(out_id),
      .out_tag(out_tag)
`ifdef FPU_FCLASS_STATS_EN
      , .stat_clr(stat_clr), .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
      .stat_nan(stat_nan)
`endif
   );

   // scoreboard: exp_q holds the result the output register should present ({id,tag,mask})
   localparam int RW = 1 + TAG_W + 10;
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] held;
   int            m_rr;
   int            n_tests = 0;
   int            n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // fclass category index computed from the field values as plain integers
   function automatic int ref_class_idx(input logic [STD:0] x);
      int v, e, m, s, emax;
      v    = int'(x);
      s    = (v >> STD) & 1;
      e    = (v >> MAN) & ((1 << EW) - 1);
      m    = v & ((1 << MAN) - 1);
      emax = (1 << EW) - 1;
      if (e == emax && m != 0) return (m >= (1 << (MAN - 1))) ? 9 : 8;
      if (e == emax)           return s ? 0 : 7;
      if (e == 0 && m == 0)    return s ? 3 : 4;
      if (e == 0)              return s ? 2 : 5;
      return s ? 1 : 6;
   endfunction

   function automatic logic [STD:0] rand_op();
      int s, e, m;
      s = $urandom_range(0, 1);
      m = $urandom_range(0, (1 << MAN) - 1);
      case ($urandom_range(0, 4))
         0: e = 0;
         1: e = (1 << EW) - 1;
         2: begin e = (1 << EW) - 1; m = 0; end
         3: begin e = 0; m = 0; end
         default: e = $urandom_range(0, (1 << EW) - 1);
      endcase
      return STD'((s << STD) | (e << MAN) | m);
   endfunction

   // driver: apply one cycle of inputs, check handshake and the registered result
   task automatic step(input logic v0, input logic [STD:0] d0, input logic [TAG_W-1:0] t0,
                       input logic v1, input logic [STD:0] d1, input logic [TAG_W-1:0] t1,
                       input logic ordy, input logic fl, input logic rs, input logic sc);
      int g;
      logic [STD:0] gd;
      @(negedge clk);
      rst = rs; flush = fl; out_ready = ordy;
      req0_valid = v0; req0_data = d0; req0_tag = t0;
      req1_valid = v1; req1_data = d1; req1_tag = t1;
`ifdef FPU_FCLASS_STATS_EN
      stat_clr = sc;
`endif
      #1;
      g = -1;
      if (!rs && !fl && (exp_q.size() == 0 || ordy)) begin
         if (v0 && v1) g = m_rr;
         else if (v0)  g = 0;
         else if (v1)  g = 1;
      end
      check("req0_ready", 32'(req0_ready), 32'(g == 0));
      check("req1_ready", 32'(req1_ready), 32'(g == 1));
      @(posedge clk);
      gd = (g == 1) ? d1 : d0;
      if (rs) begin
         exp_q.delete();
         held = '0;
         m_rr = 0;
      end else if (fl) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
         if (g >= 0) begin
            held = {g[0], (g == 1) ? t1 : t0, 10'(1 << ref_class_idx(gd))};
            exp_q.push_back(held);
            m_rr = 1 - g;
         end
      end
`ifdef FPU_FCLASS_STATS_EN
      if (rs || sc) begin
         m_g0 = 0; m_g1 = 0; m_nan = 0;
      end else if (g >= 0) begin
         if (g == 0 && m_g0 < 65535) m_g0++;
         if (g == 1 && m_g1 < 65535) m_g1++;
         if (ref_class_idx(gd) >= 8 && m_nan < 65535) m_nan++;
      end
`endif
      #1;
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("out_result", 32'({out_id, out_tag, out_mask}), 32'(held));
`ifdef FPU_FCLASS_STATS_EN
      check("stat_grant0", 32'(stat_grant0), 32'(m_g0));
      check("stat_grant1", 32'(stat_grant1), 32'(m_g1));
      check("stat_nan", 32'(stat_nan), 32'(m_nan));
`endif
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, '0, '0, 1'b0, '0, '0, ordy, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, rand_op(), 4'h3, 1'b1, rand_op(), 4'h5, 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   logic [STD:0] t1_data[6];
   logic [9:0]   t1_mask[6];

   initial begin
      held = '0;
      m_rr = 0;
`ifdef FPU_FCLASS_STATS_EN
      m_g0 = 0; m_g1 = 0; m_nan = 0;
`endif
      do_reset();
      do_reset();

      // single requester 0, back-to-back known classes
      t1_data = '{16'h7F80, 16'hBF80, 16'h0001, 16'h8000, 16'h7F81, 16'h7FC0};
      t1_mask = '{10'h080, 10'h002, 10'h020, 10'h008, 10'h100, 10'h200};
      for (int i = 0; i < 6; i++) begin
         step(1'b1, t1_data[i], 4'(i + 1), 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
         check("t1_mask", 32'(out_mask), 32'(t1_mask[i]));
         check("t1_tag", 32'(out_tag), 32'(i + 1));
         check("t1_id", 32'(out_id), 32'd0);
      end
      idle(1'b1);

      // both requesters continuously from reset: strict alternation
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, rand_op(), 4'(i), 1'b1, rand_op(), 4'(i + 8), 1'b1, 1'b0, 1'b0, 1'b0);
         check("t2_id", 32'(out_id), 32'(i % 2));
      end

      // stall: +zero held while both request, then release to the rr side
      do_reset();
      step(1'b1, 16'h0000, 4'hA, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, rand_op(), 4'h1, 1'b1, rand_op(), 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
         check("t3_hold_mask", 32'(out_mask), 32'h010);
      end
      step(1'b1, rand_op(), 4'h1, 1'b1, 16'h3C00, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t3_rr_id", 32'(out_id), 32'd1);
      check("t3_rr_mask", 32'(out_mask), 32'h040);

      // flush with a stalled result and req1 pending
      step(1'b0, '0, '0, 1'b1, 16'hFF80, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t4_flush_valid", 32'(out_valid), 32'd0);
      step(1'b0, '0, '0, 1'b1, 16'hFF80, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t4_after_mask", 32'(out_mask), 32'h001);
      check("t4_after_id", 32'(out_id), 32'd1);

      // reset mid-stream, then a contested grant goes to requester 0
      step(1'b1, rand_op(), 4'h1, 1'b1, rand_op(), 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
      do_reset();
      check("t5_rst_valid", 32'(out_valid), 32'd0);
      step(1'b1, 16'h4000, 4'h7, 1'b1, rand_op(), 4'h8, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t5_first_id", 32'(out_id), 32'd0);

`ifdef FPU_FCLASS_STATS_EN
      do_reset();
      step(1'b1, 16'h3F80, 4'h1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'hFFC1, 4'h2, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'h0000, 4'h3, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 16'h4000, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 16'h8001, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1'b1);
      check("t6_grant0", 32'(stat_grant0), 32'd3);
      check("t6_grant1", 32'(stat_grant1), 32'd2);
      check("t6_nan", 32'(stat_nan), 32'd1);
      step(1'b1, 16'h7FC0, 4'h1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("t6_clr_grant0", 32'(stat_grant0), 32'd0);
      check("t6_clr_nan", 32'(stat_nan), 32'd0);
`endif

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         step(1'($urandom_range(0, 1)), rand_op(), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), rand_op(), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 19) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_fclass_arbiter.md
Name: fpu_fclass_arbiter

Overview:
- Shares one FP classification datapath between two requesters (integer-pipe FCLASS issue port 0, FPU-internal special-case check port 1).
- Round-robin arbitration grants one operand per cycle.
- Classifies the granted operand and holds the 10-bit one-hot fclass mask in an output register under valid/ready backpressure.
- Sits between the issue logic and the FPU writeback mux.

Parameters:
- STD, 15, MSB index of operand (width = STD+1).
- MAN, 7, mantissa width; exponent = bits [STD-1:MAN].
- TAG_W, 4, width of the opaque tag carried with each request.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- flush  input  1  synchronous flush: drops held result, blocks grant this cycle
- req0_valid  input  1  requester 0 has operand
- req0_ready  output  1  requester 0 operand accepted this cycle
- req0_data  input  STD+1  requester 0 operand
- req0_tag  input  TAG_W  requester 0 tag
- req1_valid  input  1  requester 1 has operand
- req1_ready  output  1  requester 1 operand accepted this cycle
- req1_data  input  STD+1  requester 1 operand
- req1_tag  input  TAG_W  requester 1 tag
- out_valid  output  1  result held
- out_ready  input  1  consumer takes result
- out_mask  output  10  one-hot fclass mask
- out_id  output  1  requester that produced the result
- out_tag  output  TAG_W  tag of that request

Behaviour:
- Reset (rst=1): out_valid=0, out_mask=0, out_id=0, out_tag=0, rr_ptr=0 (requester 0 favoured), stats cleared. Reset is synchronous and overrides flush and all handshakes.
- slot_free = !out_valid | out_ready. A grant is possible only when slot_free=1 and flush=0.
- Arbitration when a grant is possible:
  - Only one valid: grant that requester.
  - Both valid: grant the requester at rr_ptr.
  - After any grant, rr_ptr = ~granted id.
  - With no grant, rr_ptr holds.
- reqN_ready is combinational: high only for the granted requester. Never both high. Each reqN_ready is low whenever flush=1 or slot_free=0.
- Latency is 1 cycle. On grant, the next edge loads out_valid=1, out_mask=classify(data), out_id, and out_tag.
- Back-to-back throughput is one result per cycle while out_ready=1.
- If out_valid=1 and out_ready=0, all outputs hold stable and no grant occurs.
- Result consumed with no new grant: out_valid=0 next cycle; mask, id and tag hold their old values.
- Flush: out_valid=0 next cycle and the held result is discarded. An out_ready asserted in the flush cycle is a don't-care. rr_ptr is unchanged.
- Classification uses exponent E=[STD-1:MAN], mantissa M=[MAN-1:0], sign S=[STD]. Exactly one bit is set:
  - bit0: -inf (S=1, E all ones, M=0)
  - bit1: -normal (S=1, E not 0 and not all ones)
  - bit2: -subnormal (S=1, E=0, M≠0)
  - bit3: -zero (S=1, E=0, M=0)
  - bit4: +zero
  - bit5: +subnormal
  - bit6: +normal
  - bit7: +inf
  - bit8: sNaN (E all ones, M[MAN-1]=0, M≠0)
  - bit9: qNaN (E all ones, M[MAN-1]=1, any sign and payload)
- The classifier is internal combinational logic, fully parameterized by STD and MAN.

Optional Feature:
- Macro: FPU_FCLASS_STATS_EN.
- Defined:
  - Adds outputs stat_grant0 [15:0], stat_grant1 [15:0], stat_nan [15:0] and input stat_clr.
  - stat_grant0/stat_grant1 count grants per requester.
  - stat_nan counts grants whose result is sNaN or qNaN.
  - All counters saturate at 0xFFFF and clear on rst or stat_clr.
  - stat_clr coincident with a grant: clear wins, counter is 0 next cycle.
- Undefined: these ports and counters are absent. Core behaviour is identical.

Test Plan:
- Defaults, single requester 0, out_ready=1. Send 0x7F80, 0xBF80, 0x0001, 0x8000, 0x7F81, 0x7FC0 back-to-back. Expect out_mask 0x080, 0x002, 0x020, 0x008, 0x100, 0x200 one cycle later each, out_id=0, tags echoed in order.
- Both requesters valid continuously, out_ready=1, starting from reset. Expect grants in order 0,1,0,1…; req0_ready and req1_ready never both high; out_id alternates.
- Stall: result 0x0000 held with out_ready=0 for 3 cycles while both request. Expect out_mask=0x010 stable, both readys=0. Then out_ready=1: the next grant goes to the rr_ptr side.
- Flush while out_valid=1, out_ready=0, req1_valid=1. Expect no grant that cycle and out_valid=0 next. Next cycle req1 is granted and its mask appears one cycle later.
- Assert rst mid-stream with an outstanding result and both valid. Expect out_valid=0, all readys=0 during reset; after reset, requester 0 wins the first contested grant.
- With FPU_FCLASS_STATS_EN: 3 grants to req0, 2 to req1, one of them 0xFFC1. Expect stat_grant0=3, stat_grant1=2, stat_nan=1. Pulse stat_clr and expect all counters 0.
